// File: rtl/mod12_pkg.sv
//----------------------------------------------------------------------------
// mod12_pkg : shared constants, event type and step classifier for mod-12
// Rev 1.0   : initial release
//----------------------------------------------------------------------------
`default_nettype none

package mod12_pkg;

   localparam logic [3:0] MOD12_MAX      = 4'd11;
   localparam logic [3:0] DISP_ZERO_TENS = 4'd1;
   localparam logic [3:0] DISP_ZERO_ONES = 4'd2;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_LOAD,
      EV_STEP,
      EV_CARRY,
      EV_BORROW,
      EV_ILLEGAL
   } mod12_ev_e;

   // Classifies one counter transition prev -> cur under the controls that produced it.
   function automatic mod12_ev_e classify(
      input logic       vld,
      input logic       ld,
      input logic       up,
      input logic [3:0] prev,
      input logic [3:0] cur
   );
      mod12_ev_e ev;
      ev = EV_ILLEGAL;
      if (!vld) begin
         ev = EV_NONE;
      end else if (ld) begin
         ev = EV_LOAD;
      end else if (up) begin
         if (prev == MOD12_MAX && cur == 4'd0) begin
            ev = EV_CARRY;
         end else if (prev < MOD12_MAX && cur == prev + 4'd1) begin
            ev = EV_STEP;
         end
      end else begin
         if (prev == 4'd0 && cur == MOD12_MAX) begin
            ev = EV_BORROW;
         end else if (prev != 4'd0 && prev <= MOD12_MAX && cur == prev - 4'd1) begin
            ev = EV_STEP;
         end
      end
      return ev;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mod12_wrap_monitor_if.sv
//----------------------------------------------------------------------------
// mod12_wrap_monitor_if : counter-side inputs and monitor results
// Rev 1.0               : initial release
//----------------------------------------------------------------------------
`default_nettype none

interface mod12_wrap_monitor_if #(
   parameter int TALLY_W = 8
);

   logic [3:0]         cnt;
   logic               load;
   logic               mode;
   logic               clr_err;
   logic               carry_up;
   logic               borrow_dn;
   logic               pm;
   logic [3:0]         hr_tens;
   logic [3:0]         hr_ones;
   logic [TALLY_W-1:0] tally;
   logic               step_err;
   logic               range_err;

   modport master (
      output cnt, load, mode, clr_err,
      input  carry_up, borrow_dn, pm, hr_tens, hr_ones, tally, step_err, range_err
   );

   modport slave (
      input  cnt, load, mode, clr_err,
      output carry_up, borrow_dn, pm, hr_tens, hr_ones, tally, step_err, range_err
   );

endinterface

`default_nettype wire

// File: rtl/mod12_to_bcd12.sv
//----------------------------------------------------------------------------
// mod12_to_bcd12 : combinational count -> 12-hour BCD hour (0 shows as 12)
// Rev 1.0        : initial release
//----------------------------------------------------------------------------
`default_nettype none

module mod12_to_bcd12
   import mod12_pkg::*;
(
   input  logic [3:0] cnt,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   // Results for cnt >= 12 are don't-care; the caller holds its display then.
   always_comb begin
      tens = 4'd0;
      ones = cnt;
      if (cnt == 4'd0) begin
         tens = DISP_ZERO_TENS;
         ones = DISP_ZERO_ONES;
      end else if (cnt >= 4'd10) begin
         tens = 4'd1;
         ones = cnt - 4'd10;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mod12_wrap_monitor.sv
//----------------------------------------------------------------------------
// mod12_wrap_monitor : wrap pulses, AM/PM, wrap tally, display and error flags
// Rev 1.0            : initial release
//----------------------------------------------------------------------------
`default_nettype none

module mod12_wrap_monitor
   import mod12_pkg::*;
#(
   parameter int TALLY_W = 8,
   parameter int MOD     = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   mod12_wrap_monitor_if.slave  bus
);

   logic [3:0]         prev_q, prev_d;
   logic               ld_q, ld_d;
   logic               md_q, md_d;
   logic               vld_q, vld_d;
   logic               carry_up_q, carry_up_d;
   logic               borrow_dn_q, borrow_dn_d;
   logic               pm_q, pm_d;
   logic [TALLY_W-1:0] tally_q, tally_d;
   logic               step_err_q, step_err_d;
   logic               range_err_q, range_err_d;
   logic [3:0]         hr_tens_q, hr_tens_d;
   logic [3:0]         hr_ones_q, hr_ones_d;

   logic [3:0]         bcd_tens;
   logic [3:0]         bcd_ones;
   logic               in_range;
   logic               wrap;
   mod12_ev_e          ev;

   mod12_to_bcd12 u_bcd (
      .cnt  (bus.cnt),
      .tens (bcd_tens),
      .ones (bcd_ones)
   );

   assign in_range = (int'(bus.cnt) < MOD);

   always_comb begin
      ev          = classify(vld_q, ld_q, md_q, prev_q, bus.cnt);
      carry_up_d  = (ev == EV_CARRY);
      borrow_dn_d = (ev == EV_BORROW);
      wrap        = carry_up_d | borrow_dn_d;
      pm_d        = pm_q ^ wrap;
      tally_d     = tally_q;
      if (wrap && tally_q != {TALLY_W{1'b1}}) begin
         tally_d = tally_q + TALLY_W'(1);
      end
      // A new error in the clearing cycle must survive the clear.
      step_err_d  = (step_err_q & ~bus.clr_err) | (ev == EV_ILLEGAL);
      range_err_d = (range_err_q & ~bus.clr_err) | ~in_range;
      hr_tens_d   = in_range ? bcd_tens : hr_tens_q;
      hr_ones_d   = in_range ? bcd_ones : hr_ones_q;
      prev_d      = bus.cnt;
      ld_d        = bus.load;
      md_d        = bus.mode;
      vld_d       = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q      <= 4'd0;
         ld_q        <= 1'b0;
         md_q        <= 1'b0;
         vld_q       <= 1'b0;
         carry_up_q  <= 1'b0;
         borrow_dn_q <= 1'b0;
         pm_q        <= 1'b0;
         tally_q     <= '0;
         step_err_q  <= 1'b0;
         range_err_q <= 1'b0;
         hr_tens_q   <= DISP_ZERO_TENS;
         hr_ones_q   <= DISP_ZERO_ONES;
      end else begin
         prev_q      <= prev_d;
         ld_q        <= ld_d;
         md_q        <= md_d;
         vld_q       <= vld_d;
         carry_up_q  <= carry_up_d;
         borrow_dn_q <= borrow_dn_d;
         pm_q        <= pm_d;
         tally_q     <= tally_d;
         step_err_q  <= step_err_d;
         range_err_q <= range_err_d;
         hr_tens_q   <= hr_tens_d;
         hr_ones_q   <= hr_ones_d;
      end
   end

   assign bus.carry_up  = carry_up_q;
   assign bus.borrow_dn = borrow_dn_q;
   assign bus.pm        = pm_q;
   assign bus.tally     = tally_q;
   assign bus.step_err  = step_err_q;
   assign bus.range_err = range_err_q;
   assign bus.hr_tens   = hr_tens_q;
   assign bus.hr_ones   = hr_ones_q;

endmodule

`default_nettype wire
